instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface.
- Owns the program counter and drives a 64-bit byte address to the instruction memory. The memory returns the 32-bit instruction combinationally in the same cycle.
- Captures each instruction with its PC into a small fetch queue, presented to decode over a valid/ready handshake.
- Accepts PC redirects from branch resolution (B, CBZ) and flushes stale fetches.

---
 rtl/instruction_fetch_unit_pkg.sv | 13 +
 rtl/instruction_fetch_unit_fetch_queue.sv | 75 +++++++
 rtl/instruction_fetch_unit.sv | 77 +++++++
 tb/tb_instruction_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths and the fetch-queue entry type for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Circular-buffer fetch queue with flush; head holds its last presented value while empty.
module instruction_fetch_unit_fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  fetch_entry_t                 i_data,
  output fetch_entry_t                 o_head,
  output logic                         o_valid,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  fetch_entry_t     r_last;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic         w_wr;
  logic         w_rd;
  logic         w_valid;
  fetch_entry_t w_head;

  assign w_valid = (r_count != '0);
  assign w_wr    = i_push & ~i_flush;
  assign w_rd    = i_pop & w_valid & ~i_flush;
  assign w_head  = w_valid ? r_mem[r_rd_ptr] : r_last;

  // Storage needs no reset: the head is muxed to r_last whenever the queue is empty.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= w_head;
    end else begin
      r_last <= w_head;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = w_head;
  assign o_valid = w_valid;
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address and
// buffers fetched {instruction, pc} pairs for decode; branch redirects flush the queue.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               fetch_enable,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               misalign_err
);

  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;

  logic [CNT_W-1:0]  w_count;
  logic              w_valid;
  logic              w_pop;
  logic              w_space;
  logic              w_push;
  fetch_entry_t      w_head;
  fetch_entry_t      w_wr_entry;

  assign w_pop      = w_valid & out_ready;
  assign w_space    = (w_count < FULL_CNT) | w_pop;
  assign w_push     = fetch_enable & w_space & ~redirect_valid;
  assign w_wr_entry = '{instruction: imem_instruction, pc: r_pc};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      // Low address bits are forced to zero; a misaligned target is flagged, not trapped.
      r_pc <= {redirect_target[ADDR_W-1:2], 2'b00};
      if (redirect_target[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else if (w_push) begin
      r_pc <= r_pc + ADDR_W'(INSTR_BYTES);
    end
  end

  instruction_fetch_unit_fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_queue (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wr_entry),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign imem_address    = r_pc;
  assign out_valid       = w_valid;
  assign out_instruction = w_head.instruction;
  assign out_pc          = w_head.pc;
  assign misalign_err    = r_misalign;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised scoreboard bench for instruction_fetch_unit with a queue-based reference model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int unsigned DEPTH   = 2;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] redirect_target = '0;

  logic [63:0] imem_address, imem_address2, out_pc, out_pc2;
  logic [31:0] imem_instruction, imem_instruction2, out_instruction, out_instruction2;
  logic        out_valid, out_valid2, misalign_err, misalign_err2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: next PC, sticky flag, and entries fetched but not yet consumed.
  logic [63:0]  m_pc = '0;
  bit           m_mis = 1'b0;
  fetch_entry_t sb[$];
  bit           exp_valid = 1'b0;
  logic [63:0]  exp_addr = '0;
  bit           exp_mis = 1'b0;
  fetch_entry_t mon_e;

  function automatic logic [31:0] imem_f(input logic [63:0] a);
    case (a)
      64'h00:  imem_f = 32'h9100_2041;
      64'h04:  imem_f = 32'hCB00_0842;
      64'h08:  imem_f = 32'h8A1F_0C63;
      64'h0C:  imem_f = 32'hD280_0084;
      64'h10:  imem_f = 32'hB400_0062;
      64'h14:  imem_f = 32'h9100_0421;
      64'h18:  imem_f = 32'hF100_043F;
      64'h1C:  imem_f = 32'h54FF_FFA1;
      64'h20:  imem_f = 32'h8B01_0042;
      64'h24:  imem_f = 32'hCB03_0084;
      64'h28:  imem_f = 32'h17FF_FFFD;
      64'h2C:  imem_f = 32'hAA1F_14C4;
      default: imem_f = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endcase
  endfunction

  assign imem_instruction  = imem_f(imem_address);
  assign imem_instruction2 = imem_f(imem_address2);

  instruction_fetch_unit #(
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .fetch_enable     (fetch_enable),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .misalign_err     (misalign_err)
  );

  instruction_fetch_unit #(
    .RESET_PC   (WRAP_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut_wrap (
    .CLK              (CLK),
    .RESET            (RESET),
    .fetch_enable     (fetch_enable),
    .imem_address     (imem_address2),
    .imem_instruction (imem_instruction2),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .out_valid        (out_valid2),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction2),
    .out_pc           (out_pc2),
    .misalign_err     (misalign_err2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares presented state and every accepted instruction against the scoreboard.
  always @(negedge CLK) begin
    if (!RESET) begin
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("imem_address", imem_address, exp_addr);
      chk("misalign_err", 64'(misalign_err), 64'(exp_mis));
      if (out_valid && out_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          chk("pop_with_empty_scoreboard", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("out_pc", out_pc, mon_e.pc);
          chk("out_instruction", 64'(out_instruction), 64'(mon_e.instruction));
        end
      end
    end
  end

  // Entered at posedge+2: snapshot model, apply inputs, advance model for the coming edge.
  task automatic step(input bit en, input bit rdy, input bit rv, input logic [63:0] tgt);
    bit m_pop;
    exp_valid       = (sb.size() != 0);
    exp_addr        = m_pc;
    exp_mis         = m_mis;
    fetch_enable    = en;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (rv) begin
      sb.delete();
      m_pc = tgt & ~64'h3;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      m_pop = rdy && (sb.size() != 0);
      if (en && (sb.size() < DEPTH || m_pop)) begin
        sb.push_back('{instruction: imem_f(m_pc), pc: m_pc});
        m_pc = m_pc + 64'd4;
      end
    end
    @(posedge CLK);
    #2;
  endtask

  // Asserts RESET between edges and checks the reset state before any clock edge.
  task automatic async_reset();
    #1 RESET = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imem_address", imem_address, 64'h0);
    chk("rst_imem_address_wrap", imem_address2, WRAP_PC);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_instruction", 64'(out_instruction), 64'h0);
    chk("rst_misalign_err", 64'(misalign_err), 64'd0);
    sb.delete();
    m_pc           = 64'h0;
    m_mis          = 1'b0;
    exp_valid      = 1'b0;
    exp_addr       = 64'h0;
    exp_mis        = 1'b0;
    fetch_enable   = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
  endtask

  task automatic random_phase(input int cycles, input bit allow_misalign);
    logic [63:0] tgt;
    for (int i = 0; i < cycles; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? {$urandom(), $urandom()}
                                        : 64'($urandom_range(0, 255));
      if (!allow_misalign) tgt = tgt & ~64'h3;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 11) == 0, tgt);
    end
  endtask

  initial begin
    async_reset();

    // Straight-line fetch; second instance shows the reset PC wrapping past 2^64.
    step(1, 1, 0, 0);
    chk("wrap_valid", 64'(out_valid2), 64'd1);
    chk("wrap_pc0", out_pc2, WRAP_PC);
    step(1, 1, 0, 0);
    chk("wrap_pc1", out_pc2, 64'h0);
    step(1, 1, 0, 0);
    chk("wrap_pc2", out_pc2, 64'h4);
    chk("wrap_instr2", 64'(out_instruction2), 64'h0000_0000_CB00_0842);

    // Backpressure: queue fills, PC holds, then drains in order.
    async_reset();
    repeat (5) step(1, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0);

    // Flush of a full queue by a redirect carrying a (squashed) pop.
    async_reset();
    step(1, 0, 1, 64'h18);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 1, 64'h28);
    repeat (4) step(1, 1, 0, 0);

    // Misaligned redirect is sticky across later aligned redirects.
    step(1, 1, 1, 64'h1E);
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 64'h40);
    repeat (3) step(1, 1, 0, 0);

    // PC wraps modulo 2^64 after a redirect near the top of the address space.
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (4) step(1, 1, 0, 0);

    // Back-to-back redirects and fetch_enable gaps.
    step(1, 1, 1, 64'h100);
    step(1, 1, 1, 64'h200);
    step(0, 1, 0, 0);
    step(0, 1, 1, 64'h300);
    repeat (3) step(1, 1, 0, 0);

    random_phase(300, 1'b0);

    // Reset asserted mid-cycle while the queue is full clears everything, including the flag.
    repeat (4) step(1, 0, 0, 0);
    async_reset();

    random_phase(300, 1'b1);
    repeat (3) step(1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
